uart_rx_frame_deserializer: RTL and testbench

Parametrised successor to the fixed 10-flop RX shift chain. Recovers asynchronous serial frames (start, DATA_BITS data LSB-first, optional parity, 1 or 2 stop bits) using an oversampling tick. Presents each received word through a valid/ready holding register with per-word framing, parity and overrun status. Sits between the RX pin and the UART peripheral/register interface.

---
 rtl/uart_rx_frame_deserializer.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_rx_frame_deserializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_deserializer.sv
// uart_rx_frame_deserializer
//
// Receives asynchronous serial frames from a raw RX line and presents each word through a
// valid/ready holding register. A frame is one start bit, DATA_BITS data bits sent LSB first,
// an optional parity bit, and STOP_BITS stop bits. The FSM only advances on clock cycles where
// tick_en is high. tick_en runs at OVERSAMPLE times the baud rate. Each bit is sampled once,
// at the middle of the bit, counted from the detected falling edge of the start bit.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   tick_en     oversample strobe, one clk wide, OVERSAMPLE x baud
//   ser_bit     raw RX line, asynchronous, idles high
//   data_out    received word, valid while data_valid = 1
//   data_valid  holding register full
//   data_ready  consumer accepts the word when data_valid & data_ready
//   frame_err   a stop bit of the held word was sampled low
//   parity_err  parity mismatch on the held word (always 0 without parity)
//   overrun     sticky: a held word was overwritten before it was accepted
//   busy        a frame is in progress (FSM not idle)

module uart_rx_frame_deserializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_en,
  input  logic                 ser_bit,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS);

  // Mid-bit of the start bit, measured from the tick on which the falling edge was seen.
  localparam logic [CntW-1:0] HalfTick = CntW'(OVERSAMPLE / 2 - 1);
  // From one mid-bit sample to the next one is a full bit period.
  localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
  localparam logic            HasPar   = (PARITY_EN != 0);
  localparam logic            ParOdd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Input synchroniser. It resets to the idle level, so the end of a reset never looks like a
  // start edge.
  // ---------------------------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ser_bit};
    end
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CntW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic                   perr_acc_q, perr_acc_d;
  logic                   load;
  logic                   load_ferr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ferr_acc_q <= ferr_acc_d;
      perr_acc_q <= perr_acc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ferr_acc_d = ferr_acc_q;
    perr_acc_d = perr_acc_q;
    load       = 1'b0;
    load_ferr  = ferr_acc_q;

    if (tick_en) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d    = StStart;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            ferr_acc_d = 1'b0;
            perr_acc_d = 1'b0;
          end
        end

        StStart: begin
          if (tick_cnt_q == HalfTick) begin
            tick_cnt_d = '0;
            // If the line is high again at mid-bit, the low level was a glitch. Drop the frame
            // quietly.
            state_d    = rx_s ? StIdle : StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        StData: begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            // Shift in at the MSB and move right. After DATA_BITS samples, the first bit
            // received is in bit 0.
            shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DataLast) begin
              bit_cnt_d = '0;
              state_d   = HasPar ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        StParity: begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            perr_acc_d = ((^shreg_q) ^ rx_s) != ParOdd;
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            if (bit_cnt_q == StopLast) begin
              // Go back to idle on this same tick, so a start edge on the very next tick is
              // accepted.
              load      = 1'b1;
              load_ferr = ferr_acc_q | ~rx_s;
              bit_cnt_d = '0;
              state_d   = StIdle;
            end else begin
              ferr_acc_d = ferr_acc_q | ~rx_s;
              bit_cnt_d  = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------------------------
  // Holding register and handshake. The word loads on the edge that takes the final stop sample,
  // so it appears one clk after that sample.
  // ---------------------------------------------------------------------------------------------
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 hs;

  assign hs = valid_q & data_ready;

  always_comb begin
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    valid_d = valid_q & ~data_ready;
    ovr_d   = hs ? 1'b0 : ovr_q;

    if (load) begin
      data_d  = shreg_q;
      ferr_d  = load_ferr;
      perr_d  = HasPar & perr_acc_q;
      valid_d = 1'b1;
      // A word that is consumed on this same edge is not lost, so this is not an overrun.
      if (valid_q && !data_ready) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Bench for uart_rx_frame_deserializer. Instance a uses the default frame format (8N1).
// Instance b uses even parity and two stop bits (8E2). Expected words are built from the
// frame contents that the bench chose itself.

module tb_uart_rx_frame_deserializer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic       ser_a, ser_b;
  logic       ready_a, ready_b;
  logic [7:0] dout_a, dout_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b, ovr_a, ovr_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int gap_max  = 0;

  // Captured handshakes: {overrun, parity_err, frame_err, data}
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];

  always #5 clk = ~clk;

  uart_rx_frame_deserializer u_dut (
    .clk        (clk),
    .rst        (rst),
    .tick_en    (tick_en),
    .ser_bit    (ser_a),
    .data_out   (dout_a),
    .data_valid (valid_a),
    .data_ready (ready_a),
    .frame_err  (ferr_a),
    .parity_err (perr_a),
    .overrun    (ovr_a),
    .busy       (busy_a)
  );

  uart_rx_frame_deserializer #(
    .PARITY_EN  (1),
    .PARITY_ODD (0),
    .STOP_BITS  (2)
  ) u_par (
    .clk        (clk),
    .rst        (rst),
    .tick_en    (tick_en),
    .ser_bit    (ser_b),
    .data_out   (dout_b),
    .data_valid (valid_b),
    .data_ready (ready_b),
    .frame_err  (ferr_b),
    .parity_err (perr_b),
    .overrun    (ovr_b),
    .busy       (busy_b)
  );

  // Record each word at the handshake, sampling between clock edges.
  always @(negedge clk) begin
    #1;
    if (valid_a && ready_a) q_a.push_back({ovr_a, perr_a, ferr_a, dout_a});
    if (valid_b && ready_b) q_b.push_back({ovr_b, perr_b, ferr_b, dout_b});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one delivered word, built from the frame's contents.
  function automatic logic [10:0] model(input int sel, input logic [7:0] d, input logic p,
                                        input logic s0, input logic s1);
    logic ferr, perr;
    if (sel == 0) begin
      ferr = (s0 == 1'b0);
      perr = 1'b0;
    end else begin
      ferr = (s0 == 1'b0) || (s1 == 1'b0);
      perr = ((^d) ^ p) != 1'b0;
    end
    return {1'b0, perr, ferr, d};
  endfunction

  task automatic one_tick();
    tick_en = 1'b1;
    @(negedge clk);
    if (gap_max > 0) begin
      int g;
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        tick_en = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) ser_a = v;
    else ser_b = v;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    set_line(sel, v);
    repeat (OS) one_tick();
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic p, input logic s0,
                            input logic s1);
    logic last;
    drive_bit(sel, 1'b0);
    check("busy_in_frame", 32'(sel == 0 ? busy_a : busy_b), 32'd1);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (sel == 1) drive_bit(sel, p);
    drive_bit(sel, s0);
    last = s0;
    if (sel == 1) begin
      drive_bit(sel, s1);
      last = s1;
    end
    // After a high final stop bit, the receiver must already be idle.
    if (last) check("busy_after_stop", 32'(sel == 0 ? busy_a : busy_b), 32'd0);
    set_line(sel, 1'b1);
    repeat (24) one_tick();
  endtask

  task automatic expect_word(input int sel, input logic [10:0] exp, input string tag);
    int          n;
    logic [10:0] w;
    n = (sel == 0) ? q_a.size() : q_b.size();
    check({tag, "_count"}, 32'(n), 32'd1);
    if (n > 0) begin
      w = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
      check({tag, "_word"}, 32'(w), 32'(exp));
    end
    while (q_a.size() > 0 && sel == 0) void'(q_a.pop_front());
    while (q_b.size() > 0 && sel == 1) void'(q_b.pop_front());
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s0, s1;

    rst     = 1'b0;
    tick_en = 1'b0;
    ser_a   = 1'b1;
    ser_b   = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    #2;
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_dout", 32'(dout_a), 32'd0);
    check("rst_flags", 32'({ovr_a, perr_a, ferr_a}), 32'd0);
    check("rst_b_outs", 32'({valid_b, busy_b, ovr_b, perr_b, ferr_b, dout_b}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) one_tick();

    // Basic 8N1 word
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    expect_word(0, model(0, 8'hA5, 1'b0, 1'b1, 1'b1), "a5");

    // Glitch shorter than half a bit
    ser_a = 1'b0;
    repeat (4) one_tick();
    check("glitch_busy", 32'(busy_a), 32'd1);
    ser_a = 1'b1;
    repeat (12) one_tick();
    check("glitch_idle", 32'(busy_a), 32'd0);
    check("glitch_noword", 32'(q_a.size()), 32'd0);
    repeat (8) one_tick();

    // Even parity, two stop bits
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    expect_word(1, model(1, 8'h03, 1'b1, 1'b1, 1'b1), "par_bad");
    send_frame(1, 8'h03, 1'b0, 1'b1, 1'b1);
    expect_word(1, model(1, 8'h03, 1'b0, 1'b1, 1'b1), "par_ok");
    send_frame(1, 8'h5A, 1'b0, 1'b1, 1'b0);
    expect_word(1, model(1, 8'h5A, 1'b0, 1'b1, 1'b0), "stop2_low");
    check("stop2_ferr_pin", 32'(ferr_b), 32'd1);

    // Overrun
    ready_a = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    #1;
    check("ovr_first_valid", 32'(valid_a), 32'd1);
    check("ovr_first_word", 32'({ovr_a, dout_a}), 32'({1'b0, 8'h11}));
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
    #1;
    check("ovr_valid", 32'(valid_a), 32'd1);
    check("ovr_data", 32'(dout_a), 32'h22);
    check("ovr_flag", 32'(ovr_a), 32'd1);
    @(negedge clk);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    #1;
    check("ovr_clr_valid", 32'(valid_a), 32'd0);
    check("ovr_clr_flag", 32'(ovr_a), 32'd0);
    check("ovr_held_data", 32'(dout_a), 32'h22);
    expect_word(0, {1'b1, 2'b00, 8'h22}, "ovr_hs");
    ready_a = 1'b1;

    // Reset during data bit 4 abandons the frame
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    ser_a = 1'b1;
    repeat (8) one_tick();
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_dout", 32'(dout_a), 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (32) one_tick();
    check("midrst_noword", 32'(q_a.size()), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    expect_word(0, model(0, 8'h3C, 1'b0, 1'b1, 1'b1), "after_rst");

    // Random frames, with random gaps between ticks on half of them
    for (int k = 0; k < 24; k++) begin
      int sel;
      sel     = k % 2;
      gap_max = (k >= 12) ? 2 : 0;
      d       = 8'($urandom);
      p       = 1'($urandom);
      s0      = ($urandom_range(0, 3) != 0);
      s1      = ($urandom_range(0, 3) != 0);
      send_frame(sel, d, p, s0, s1);
      expect_word(sel, model(sel, d, p, s0, s1), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
